// File: rtl/divrest_param.sv
// Parametrised restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one cycle. In the normal
// path, optional early-out skips the dividend's leading zeros. Operands
// are captured when start is accepted.
// Start handshake: start_in is accepted on any rising edge where busy==0,
// including the cycle in which done==1. While busy==1, start_in is ignored.
// done pulses for one cycle when q_out/r_out/dbz are updated.
module divrest_param #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rstLow,
    input  logic             start_in,
    input  logic             signed_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [1:0]       state_dbg_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_LOOP = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // raw dividend as sampled
    logic [WIDTH-1:0] b_q, b_d;        // raw divisor, then |b| from PREP on
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] q_q, q_d;        // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] r_q, r_d;        // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] qo_q, qo_d;
    logic [WIDTH-1:0] ro_q, ro_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    clz_v;

    // Count of leading zeros; an all-zero word yields WIDTH.
    function automatic logic [CW-1:0] clz_f(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CNT_FULL;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    // Next-state logic for the IDLE/PREP/LOOP/FIX sequencer and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        qo_d    = qo_q;
        ro_d    = ro_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        abs_a = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        clz_v = EARLY_OUT ? clz_f(abs_a) : '0;
        trial = {r_q, q_q[WIDTH-1]} - {1'b0, b_q};

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    a_d   = a_in;
                    b_d   = b_in;
                    sgn_d = signed_in;
                    if (b_in == '0) begin
                        qo_d   = '1;
                        ro_d   = a_in;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (signed_in && a_in == MIN_NEG && b_in == '1) begin
                        qo_d   = a_in;
                        ro_d   = '0;
                        dbz_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_PREP;
                    end
                end
            end
            S_PREP: begin
                b_d    = abs_b;
                negq_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                negr_d = sgn_q & a_q[WIDTH-1];
                r_d    = '0;
                if (abs_a == '0) begin
                    // Zero dividend: nothing to iterate, result is 0 rem 0.
                    cnt_d   = CNT_FULL;
                    q_d     = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = clz_v;
                    q_d     = abs_a << clz_v;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            default: begin  // S_FIX
                qo_d    = negq_q ? -q_q : q_q;
                ro_d    = negr_q ? -r_q : r_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            qo_q    <= '0;
            ro_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            qo_q    <= qo_d;
            ro_q    <= ro_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign q_out       = qo_q;
    assign r_out       = ro_q;
    assign dbz         = dbz_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg_o = state_q;

endmodule
